// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for data_memory_responder: FSM state enum, wait-counter
// width and the data window checked when DATA_MEMORY_RESPONDER_ERROR_EN is defined.
package data_memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam int WAIT_CNT_WIDTH = 4;

    // Byte-address window of the data region in the system memory map.
    localparam logic [31:0] DATA_BEGIN = 32'h0000_0000;
    localparam logic [31:0] DATA_END   = 32'h0001_FFFC;

    // Offset form keeps the test free of always-true compares when DATA_BEGIN is zero.
    function automatic logic addr_in_range(input logic [31:0] byte_addr);
        return (byte_addr - DATA_BEGIN) <= (DATA_END - DATA_BEGIN);
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// Byte-enabled synchronous RAM, one 8-bit array per lane, one-cycle registered read
// (read-before-write on a same-address write).
module data_memory_array #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [3:0]            byteena,
    input  logic [31:0]           data,
    input  logic                  wren,
    output logic [31:0]           q
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clock) begin
                if (wren && byteena[gi]) begin
                    lane_mem[address] <= data[gi*8 +: 8];
                end
                q[gi*8 +: 8] <= lane_mem[address];
            end
        end
    endgenerate

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for the core data port: one outstanding request, WAIT_STATES
// delay, byte-enabled RAM. Optional range check via DATA_MEMORY_RESPONDER_ERROR_EN.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 15,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [3:0]  req_byteena,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_WIDTH'(WAIT_STATES - 1) : '0;

    resp_state_t               state_reg, state_next;
    logic [WAIT_CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                      write_reg;
    logic [29:0]               word_addr_reg;
    logic [3:0]                byteena_reg;
    logic [31:0]               wdata_reg;
    logic                      error_reg;

    logic        in_idle;
    logic        accept;
    logic        access_en;
    logic        access_write;
    logic        access_error;
    logic [29:0] access_word;
    logic [3:0]  access_byteena;
    logic [31:0] access_wdata;
    logic        ram_wren;
    logic [31:0] ram_q;

    assign in_idle = (state_reg == IDLE);
    assign accept  = in_idle && req_valid;

    // With no wait states the access happens on the accept edge, so it uses the live request.
    assign access_word    = in_idle ? req_address[31:2] : word_addr_reg;
    assign access_write   = in_idle ? req_write         : write_reg;
    assign access_byteena = in_idle ? req_byteena       : byteena_reg;
    assign access_wdata   = in_idle ? req_wdata         : wdata_reg;

`ifdef DATA_MEMORY_RESPONDER_ERROR_EN
    assign access_error = !addr_in_range({access_word, 2'b00});
`else
    assign access_error = 1'b0;
`endif

    assign ram_wren = access_en && access_write && !access_error && reset_n;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        access_en  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        state_next = RESP;
                        access_en  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                    access_en  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - WAIT_CNT_WIDTH'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            write_reg     <= 1'b0;
            word_addr_reg <= '0;
            byteena_reg   <= '0;
            wdata_reg     <= '0;
            error_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                write_reg     <= req_write;
                word_addr_reg <= req_address[31:2];
                byteena_reg   <= req_byteena;
                wdata_reg     <= req_wdata;
                error_reg     <= access_error;
            end
        end
    end

    data_memory_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clock   (clock),
        .address (access_word[ADDR_WIDTH-1:0]),
        .byteena (access_byteena),
        .data    (access_wdata),
        .wren    (ram_wren),
        .q       (ram_q)
    );

    // RAM address stays on the latched word during RESP, so ram_q is stable there.
    assign req_ready = in_idle;
    assign rsp_valid = (state_reg == RESP);
    assign rsp_error = rsp_valid && error_reg;
    assign rsp_rdata = (rsp_valid && !write_reg && !error_reg) ? ram_q : 32'h0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_address[1:0], word_addr_reg[29:ADDR_WIDTH]};

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder (WAIT_STATES=2 main instance, WAIT_STATES=0
// back-to-back instance). Error cases run when DATA_MEMORY_RESPONDER_ERROR_EN is defined.
`timescale 1ns/1ps
module tb_data_memory_responder;
    localparam int AW    = 15;
    localparam int WS    = 2;
    localparam int AW_B  = 6;
    localparam int TMO   = 40;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_address, req_wdata;
    logic [3:0]  req_byteena;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [31:0] b_req_address, b_req_wdata;
    logic [3:0]  b_req_byteena;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_error;
    logic [31:0] b_rsp_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [int];
    logic [31:0] b_model [64];

    data_memory_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_byteena(req_byteena), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error)
    );

    data_memory_responder #(.ADDR_WIDTH(AW_B), .WAIT_STATES(0)) dut_b2b (
        .clock(clock), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_address(b_req_address), .req_byteena(b_req_byteena), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_error(b_rsp_error)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic int key_of(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << AW));
    endfunction

    // Drives one request on the main instance and returns the response and its latency
    // in cycles, counting the accept cycle as 1. lat=-1 means it was never accepted.
    task automatic transact(input logic w, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd, input int hold,
                            output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clock);
        n = 0;
        while (!req_ready && n < TMO) begin
            @(negedge clock);
            n++;
        end
        rd = 32'hx; er = 1'bx;
        if (!req_ready) begin
            lat = -1;
            return;
        end
        req_valid = 1'b1; req_write = w; req_address = a; req_byteena = be; req_wdata = wd;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < TMO) begin
            @(negedge clock);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_error;
        repeat (hold) @(negedge clock);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 0; req_write = 0; req_address = 0; req_byteena = 0; req_wdata = 0;
        rsp_ready = 0;
        b_req_valid = 0; b_req_write = 0; b_req_address = 0; b_req_byteena = 0; b_req_wdata = 0;
        b_rsp_ready = 0;
        repeat (3) @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
        checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp_error: got %b expected 0", rsp_error); end
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready: got %b expected 1", req_ready); end
        $display("test_reset: done");
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        transact(1'b1, 32'h0, 4'hF, 32'hDEADBEEF, 0, rd, er, lat);
        model[0] = 32'hDEADBEEF;
        checks++; if (lat !== WS + 1) begin failures++; $display("FAIL store_latency: got %0d expected %0d", lat, WS + 1); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL store_rdata: got %h expected 0", rd); end
        $display("store 0x0 <= deadbeef lat=%0d", lat);
        transact(1'b0, 32'h0, 4'h0, 32'h0, 0, rd, er, lat);
        checks++; if (lat !== WS + 1) begin failures++; $display("FAIL load_latency: got %0d expected %0d", lat, WS + 1); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata: got %h expected deadbeef", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL load_error: got %b expected 0", er); end
        $display("load 0x0 => %h lat=%0d", rd, lat);
    endtask

    task automatic test_byteena();
        logic [31:0] rd; logic er; int lat;
        transact(1'b1, 32'h10, 4'hF, 32'h11223344, 0, rd, er, lat);
        model[key_of(32'h10)] = 32'h11223344;
        transact(1'b1, 32'h10, 4'b0010, 32'h0000AA00, 1, rd, er, lat);
        model[key_of(32'h10)] = merge(model[key_of(32'h10)], 32'h0000AA00, 4'b0010);
        transact(1'b0, 32'h13, 4'h0, 32'h0, 0, rd, er, lat);
        checks++; if (rd !== 32'h1122AA44) begin failures++; $display("FAIL byteena_0010: got %h expected 1122aa44", rd); end
        $display("load 0x10 after lane-1 store => %h", rd);
        transact(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 0, rd, er, lat);
        checks++; if (lat !== WS + 1) begin failures++; $display("FAIL byteena_0000_response: latency %0d expected %0d", lat, WS + 1); end
        transact(1'b0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat);
        checks++; if (rd !== model[key_of(32'h10)]) begin failures++; $display("FAIL byteena_0000_unchanged: got %h expected %h", rd, model[key_of(32'h10)]); end
        $display("load 0x10 after empty store => %h", rd);
    endtask

    task automatic test_stall();
        logic [31:0] rd, exp; logic er; int lat, n;
        transact(1'b1, 32'h20, 4'hF, 32'h55AA55AA, 0, rd, er, lat);
        model[key_of(32'h20)] = 32'h55AA55AA;
        exp = model[key_of(32'h10)];
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_address = 32'h10; req_byteena = 4'h0;
        @(posedge clock);
        @(negedge clock);
        // Stray store held on the bus while the block is busy; it must be ignored.
        req_write = 1'b1; req_address = 32'h20; req_byteena = 4'hF; req_wdata = 32'hBAD0BAD0;
        n = 1;
        while (!rsp_valid && n < TMO) begin
            @(negedge clock);
            n++;
        end
        checks++; if (!rsp_valid) begin failures++; $display("FAIL stall_timeout: no response within %0d cycles", TMO); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL stall_rsp_valid[%0d]: got %b expected 1", i, rsp_valid); end
            checks++; if (rsp_rdata !== exp) begin failures++; $display("FAIL stall_rsp_rdata[%0d]: got %h expected %h", i, rsp_rdata, exp); end
            checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL stall_req_ready[%0d]: got %b expected 0", i, req_ready); end
            @(negedge clock);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        transact(1'b0, 32'h20, 4'h0, 32'h0, 0, rd, er, lat);
        checks++; if (rd !== 32'h55AA55AA) begin failures++; $display("FAIL stall_stray_ignored: got %h expected 55aa55aa", rd); end
        $display("stall: held 5 cycles, 0x20 => %h", rd);
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd; logic er; int lat;
        transact(1'b1, 32'h40, 4'hF, 32'h0BADF00D, 0, rd, er, lat);
        model[key_of(32'h40)] = 32'h0BADF00D;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_address = 32'h40; req_byteena = 4'hF;
        req_wdata = 32'hCAFEBABE;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        req_valid = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL async_reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL async_reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL async_reset_rsp_rdata: got %h expected 0", rsp_rdata); end
        checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL async_reset_rsp_error: got %b expected 0", rsp_error); end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        transact(1'b0, 32'h40, 4'h0, 32'h0, 0, rd, er, lat);
        checks++; if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL reset_drops_store: got %h expected 0badf00d", rd); end
        $display("reset in WAIT: 0x40 => %h", rd);
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, exp; logic er, w; logic [3:0] be; int lat, k;
        for (int i = 0; i < 56; i++) begin
            k  = (i < 16) ? i : int'($urandom_range(0, 15));
            w  = (i < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            be = (i < 16) ? 4'hF : 4'($urandom);
            wd = $urandom;
            a  = (32'(k) << 2) | 32'($urandom_range(0, 3));
`ifndef DATA_MEMORY_RESPONDER_ERROR_EN
            a  = a | ($urandom << (AW + 2));
`endif
            transact(w, a, be, wd, int'($urandom_range(0, 2)), rd, er, lat);
            if (w) begin
                model[key_of(a)] = (i < 16) ? wd : merge(model[key_of(a)], wd, be);
                exp = 32'h0;
            end else begin
                exp = model[key_of(a)];
            end
            checks++; if (lat !== WS + 1) begin failures++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, WS + 1); end
            checks++; if (rd !== exp) begin failures++; $display("FAIL random_rdata[%0d]: got %h expected %h", i, rd, exp); end
            $display("random %0d: %s a=%h be=%b wd=%h rd=%h", i, w ? "st" : "ld", a, be, wd, rd);
        end
    endtask

`ifdef DATA_MEMORY_RESPONDER_ERROR_EN
    task automatic test_error();
        logic [31:0] rd, bad; logic er; int lat;
        bad = data_memory_responder_pkg::DATA_END + 32'd4;
        transact(1'b0, bad, 4'h0, 32'h0, 0, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL error_load_flag: got %b expected 1", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL error_load_rdata: got %h expected 0", rd); end
        checks++; if (lat !== WS + 1) begin failures++; $display("FAIL error_latency: got %0d expected %0d", lat, WS + 1); end
        transact(1'b1, bad, 4'hF, 32'h12345678, 0, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL error_store_flag: got %b expected 1", er); end
        transact(1'b0, bad & ((32'd1 << (AW + 2)) - 1), 4'h0, 32'h0, 0, rd, er, lat);
        checks++; if (rd !== model[key_of(bad)]) begin failures++; $display("FAIL error_store_no_write: got %h expected %h", rd, model[key_of(bad)]); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL error_inrange_flag: got %b expected 0", er); end
        $display("error: out-of-range load/store flagged, aliased word => %h", rd);
    endtask
`endif

    task automatic test_back_to_back();
        int idx, k;
        logic exp_valid, pend_load;
        logic [31:0] pend_exp, wd;
        idx = 0; pend_load = 1'b0; pend_exp = 32'h0;
        b_rsp_ready = 1'b1;
        @(negedge clock);
        for (int c = 0; c < 24; c++) begin
            exp_valid = (c % 2 == 1);
            checks++; if (b_rsp_valid !== exp_valid) begin failures++; $display("FAIL b2b_rsp_valid[%0d]: got %b expected %b", c, b_rsp_valid, exp_valid); end
            checks++; if (b_req_ready !== !exp_valid) begin failures++; $display("FAIL b2b_req_ready[%0d]: got %b expected %b", c, b_req_ready, !exp_valid); end
            if (exp_valid && pend_load) begin
                checks++; if (b_rsp_rdata !== pend_exp) begin failures++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", c, b_rsp_rdata, pend_exp); end
                $display("b2b cycle %0d: load => %h", c, b_rsp_rdata);
            end
            if (c % 2 == 0 && idx < 12) begin
                k  = (idx < 6) ? idx : 11 - idx;
                wd = $urandom;
                b_req_valid = 1'b1; b_req_write = (idx < 6); b_req_address = 32'(k) << 2;
                b_req_byteena = 4'hF; b_req_wdata = wd;
                if (idx < 6) begin
                    b_model[k] = wd;
                    pend_load = 1'b0;
                end else begin
                    pend_load = 1'b1;
                    pend_exp = b_model[k];
                end
                idx++;
            end
            @(negedge clock);
        end
        b_req_valid = 1'b0;
        b_rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byteena();
        test_stall();
        test_reset_wait();
        test_random();
`ifdef DATA_MEMORY_RESPONDER_ERROR_EN
        test_error();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
